keypad_scanner: RTL and testbench

Drives the columns of a 4x4 matrix keypad one at a time and samples the row lines. Produces the 16-bit keys_pressed vector consumed by jitter_controller, which debounces it and emits key_pressed_value/new_key. Sits between the FPGA keypad pins and jitter_controller. A full-scan snapshot is updated atomically once per scan.

---
 rtl/keypad_pkg.sv | 17 +
 rtl/sync_n.sv | 29 ++
 rtl/keypad_scanner.sv | 105 ++++++++++
 tb/tb_keypad_scanner.sv | 137 +++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad geometry, scan FSM state type and key-index helper.
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;
   localparam int KEYS     = 16;

   typedef enum logic {
      SETTLE = 1'b0,
      SAMPLE = 1'b1
   } scan_state_t;

   function automatic logic [3:0] key_index(input logic [1:0] col, input logic [1:0] row);
      return 4'(NUM_ROWS * int'(col) + int'(row));
   endfunction

endpackage

// File: rtl/sync_n.sv
// Multi-flop synchronizer for asynchronous inputs; resets to all-ones (idle pulled-up lines).
module sync_n #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   if (DEPTH < 2) begin : g_chk_depth
      $error("sync_n: DEPTH must be >= 2");
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '1;
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner producing an atomic 16-bit snapshot once per scan.
// Optional macro GHOST_REJECT_EN: snapshots with more than two keys keep the previous value.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_ROWS-1:0] rows,
   output logic [NUM_COLS-1:0] cols,
   output logic [KEYS-1:0]     keys_pressed,
   output logic                scan_done
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   if (SYNC_STAGES < 2) begin : g_chk_sync
      $error("keypad_scanner: SYNC_STAGES must be >= 2");
   end
   if (SETTLE_CYCLES < SYNC_STAGES + 1) begin : g_chk_settle
      $error("keypad_scanner: SETTLE_CYCLES must be >= SYNC_STAGES+1");
   end

   scan_state_t         state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          col_q, col_d;
   logic [KEYS-1:0]     shadow_q, shadow_d;
   logic [KEYS-1:0]     keys_q, keys_d;
   logic                done_q, done_d;
   logic [NUM_COLS-1:0] cols_q;
   logic [NUM_ROWS-1:0] rows_sync;
   logic [KEYS-1:0]     snapshot;

   sync_n #(
      .WIDTH (NUM_ROWS),
      .DEPTH (SYNC_STAGES)
   ) u_row_sync (
      .clk_i   (clk),
      .rst_n_i (reset),
      .d_i     (rows),
      .q_o     (rows_sync)
   );

   // Column 3 nibble comes straight from the rows so the snapshot is complete on its SAMPLE cycle.
   assign snapshot = {~rows_sync, shadow_q[11:0]};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      col_d    = col_q;
      shadow_d = shadow_q;
      keys_d   = keys_q;
      done_d   = 1'b0;
      case (state_q)
         SETTLE: begin
            if (cnt_q == CNT_LAST) state_d = SAMPLE;
            else                   cnt_d   = cnt_q + CNT_W'(1);
         end
         SAMPLE: begin
            shadow_d[key_index(col_q, 2'd0) +: NUM_ROWS] = ~rows_sync;
            col_d   = col_q + 2'd1;
            cnt_d   = '0;
            state_d = SETTLE;
            if (col_q == 2'd3) begin
               done_d = 1'b1;
`ifdef GHOST_REJECT_EN
               if ($countones(snapshot) <= 2) keys_d = snapshot;
`else
               keys_d = snapshot;
`endif
            end
         end
         default: state_d = SETTLE;
      endcase
   end

   // Column drive lags the FSM by one clock, so each column is visible for the full dwell including SAMPLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= SETTLE;
         cnt_q    <= '0;
         col_q    <= 2'd0;
         shadow_q <= '0;
         keys_q   <= '0;
         done_q   <= 1'b0;
         cols_q   <= 4'b1111;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         col_q    <= col_d;
         shadow_q <= shadow_d;
         keys_q   <= keys_d;
         done_q   <= done_d;
         cols_q   <= ~(4'b0001 << col_q);
      end
   end

   assign cols         = cols_q;
   assign keys_pressed = keys_q;
   assign scan_done    = done_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with a combinational keypad matrix model.
module tb_keypad_scanner;

   logic        clk;
   logic        reset;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic [15:0] keys_pressed;
   logic        scan_done;
   logic [15:0] held;

   int checksTotal  = 0;
   int checksPassed = 0;

   keypad_scanner #(
      .SETTLE_CYCLES (4),
      .SYNC_STAGES   (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rows         (rows),
      .cols         (cols),
      .keys_pressed (keys_pressed),
      .scan_done    (scan_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A held key pulls its row low only while its column is driven low.
   always_comb begin
      rows = 4'b1111;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (!cols[c] && held[4*c+r]) rows[r] = 1'b0;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checksTotal++;
      if (observed === expected) checksPassed++;
      else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
   endtask

   task automatic applyStimulus(input logic [15:0] pattern);
      held = pattern;
   endtask

   // Returns at the negedge where scan_done is seen high, or after the budget expires.
   task automatic waitScanDone(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!scan_done && n < 60);
      checkOutput({tag, "_doneSeen"}, {31'd0, scan_done}, 32'd1);
   endtask

   initial begin
      logic [3:0] expCols;
      int         edges;

      held  = 16'h0000;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rstCols", {28'd0, cols}, 32'hF);
      checkOutput("rstKeys", {16'd0, keys_pressed}, 32'h0);
      checkOutput("rstDone", {31'd0, scan_done}, 32'd0);

      // Two full scans after release: column walk and scan_done timing.
      reset = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         expCols = ~(4'b0001 << ((k / 5) % 4));
         checkOutput("colsWalk", {28'd0, cols}, {28'd0, expCols});
         checkOutput("doneWalk", {31'd0, scan_done}, {31'd0, (k == 19 || k == 39)});
         if (k == 19) checkOutput("idleKeys", {16'd0, keys_pressed}, 32'h0);
      end

      applyStimulus(16'h0040);
      waitScanDone("c1r2");
      checkOutput("c1r2Keys", {16'd0, keys_pressed}, 32'h0040);
      repeat (7) @(negedge clk);
      checkOutput("c1r2Hold", {16'd0, keys_pressed}, 32'h0040);
      checkOutput("c1r2NoDone", {31'd0, scan_done}, 32'd0);
      waitScanDone("c1r2Again");
      checkOutput("c1r2Stable", {16'd0, keys_pressed}, 32'h0040);

      applyStimulus(16'h0000);
      waitScanDone("release");
      checkOutput("releaseKeys", {16'd0, keys_pressed}, 32'h0000);

      applyStimulus(16'h8001);
      waitScanDone("corners");
      checkOutput("cornersKeys", {16'd0, keys_pressed}, 32'h8001);

      applyStimulus(16'h0001);
      waitScanDone("single");
      checkOutput("singleKeys", {16'd0, keys_pressed}, 32'h0001);

      applyStimulus(16'h0013);
      waitScanDone("ghost");
`ifdef GHOST_REJECT_EN
      checkOutput("ghostKeys", {16'd0, keys_pressed}, 32'h0001);
`else
      checkOutput("ghostKeys", {16'd0, keys_pressed}, 32'h0013);
`endif

      // Reset in the middle of a scan while column 2 is driven.
      applyStimulus(16'h0040);
      waitScanDone("preReset");
      checkOutput("preResetKeys", {16'd0, keys_pressed}, 32'h0040);
      edges = 0;
      while (cols !== 4'b1011 && edges < 40) begin
         @(negedge clk);
         edges++;
      end
      checkOutput("reachCol2", {28'd0, cols}, 32'hB);
      reset = 1'b0;
      #1;
      checkOutput("midRstCols", {28'd0, cols}, 32'hF);
      checkOutput("midRstKeys", {16'd0, keys_pressed}, 32'h0);
      checkOutput("midRstDone", {31'd0, scan_done}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      edges = 0;
      do begin
         @(negedge clk);
         edges++;
      end while (!scan_done && edges < 60);
      checkOutput("restartEdges", edges, 32'd20);
      checkOutput("restartKeys", {16'd0, keys_pressed}, 32'h0040);

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
